// File: rtl/mem_bist_pkg.sv
// Shared definitions for the memory BIST: FSM state codes and their debug
// encoding, the test pattern and the saturating error-counter increment.
package mem_bist_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WR_REQ = 3'd1;
    localparam state_t ST_WR_GAP = 3'd2;
    localparam state_t ST_RD_REQ = 3'd3;
    localparam state_t ST_RD_GAP = 3'd4;
    localparam state_t ST_FINISH = 3'd5;

    // Debug view of the FSM: state code zero-extended to 16 bits.
    function automatic logic [15:0] state_debug(input state_t st);
        return {13'd0, st};
    endfunction

    // Data written to (and expected back from) a given byte address.
    function automatic logic [31:0] bist_pattern(input logic [31:0] addr,
                                                 input logic [31:0] seed);
        return addr ^ seed;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mem_bist_watchdog.sv
// Per-transaction timeout: a down-counter reloaded whenever no request is
// outstanding or an ack arrives; expires on terminal count while a request
// is still waiting.
module mem_bist_watchdog
    import mem_bist_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic active,
    output logic expire
);

    localparam logic [15:0] RELOAD = 16'(TIMEOUT - 32'd1);

    logic [15:0] count;

    // Count down one per waiting cycle; reload between transactions and on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RELOAD;
        end else if (clear || !active) begin
            count <= RELOAD;
        end else if (count != 16'd0) begin
            count <= count - 16'd1;
        end
    end

    // Terminal count reached in the TIMEOUT-th waiting cycle; a same-cycle ack wins.
    assign expire = active && !clear && (count == 16'd0);

endmodule

// File: rtl/mem_bist.sv
// Memory built-in self test: writes an address^seed pattern over a block of
// 32-bit words, reads it back and compares, with a per-transaction timeout.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start_i; bus quiet
// WR_REQ    | write request on the bus, waiting for ack
// WR_GAP    | one idle bus cycle after a write ack
// RD_REQ    | read request on the bus, waiting for ack; compare on ack
// RD_GAP    | one idle bus cycle after a read ack
// FINISH    | run over; done/pass/busy update on the way out
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned WORDS     = 1024,
    parameter int unsigned TIMEOUT   = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] seed_i,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    output logic        bus_we_o,
    output logic        bus_rd_o,
    input  logic        bus_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [15:0] err_count_o,
    output logic [31:0] first_err_addr_o,
    output logic [15:0] state_value
);

    localparam logic [15:0] WORDS_M1 = 16'(WORDS - 32'd1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] seed_q;
    logic [15:0] words_left;
    logic        last_word;
    logic        req_active;
    logic        ack_req;
    logic        start_ok;
    logic        last_now;
    logic        rd_miss;
    logic        wd_expire;
    logic [31:0] addr_next;

    assign req_active = (state == ST_WR_REQ) || (state == ST_RD_REQ);
    // Acks outside a request state are spurious and must not move anything.
    assign ack_req    = req_active && bus_ack_i;
    assign start_ok   = (state == ST_IDLE) && start_i;
    assign last_now   = (words_left == 16'd0);
    assign addr_next  = bus_addr_o + 32'd4;
    assign rd_miss    = (state == ST_RD_REQ) && bus_ack_i &&
                        (bus_data_i != bist_pattern(bus_addr_o, seed_q));

    mem_bist_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus_ack_i),
        .active (req_active),
        .expire (wd_expire)
    );

    // Next-state decode; ack takes priority over a same-cycle expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_i) state_nxt = ST_WR_REQ;
            end
            ST_WR_REQ: begin
                if (bus_ack_i)      state_nxt = ST_WR_GAP;
                else if (wd_expire) state_nxt = ST_FINISH;
            end
            ST_WR_GAP: begin
                state_nxt = last_word ? ST_RD_REQ : ST_WR_REQ;
            end
            ST_RD_REQ: begin
                if (bus_ack_i)      state_nxt = ST_RD_GAP;
                else if (wd_expire) state_nxt = ST_FINISH;
            end
            ST_RD_GAP: begin
                state_nxt = last_word ? ST_FINISH : ST_RD_REQ;
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered bus drive: strobes follow the next state so they drop the
    // cycle after ack or expiry; address/data advance only on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we_o   <= 1'b0;
            bus_rd_o   <= 1'b0;
            bus_addr_o <= 32'd0;
            bus_data_o <= 32'd0;
        end else begin
            bus_we_o <= (state_nxt == ST_WR_REQ);
            bus_rd_o <= (state_nxt == ST_RD_REQ);
            if (start_ok) begin
                bus_addr_o <= BASE_ADDR;
                bus_data_o <= bist_pattern(BASE_ADDR, seed_i);
            end else if (ack_req) begin
                if (last_now) begin
                    bus_addr_o <= BASE_ADDR;
                    bus_data_o <= bist_pattern(BASE_ADDR, seed_q);
                end else begin
                    bus_addr_o <= addr_next;
                    bus_data_o <= bist_pattern(addr_next, seed_q);
                end
            end
        end
    end

    // Word down-counter; last_word tells the GAP state whether a pass is over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_left <= 16'd0;
            last_word  <= 1'b0;
        end else if (start_ok) begin
            words_left <= WORDS_M1;
            last_word  <= 1'b0;
        end else if (ack_req) begin
            last_word  <= last_now;
            words_left <= last_now ? WORDS_M1 : words_left - 16'd1;
        end
    end

    // Seed is captured once per accepted start and held for the whole run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q <= 32'd0;
        end else if (start_ok) begin
            seed_q <= seed_i;
        end
    end

    // Run status, error tracking and the end-of-run verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            timeout_o        <= 1'b0;
            err_count_o      <= 16'd0;
            first_err_addr_o <= 32'd0;
        end else begin
            done_o <= (state == ST_FINISH);
            if (start_ok) begin
                busy_o           <= 1'b1;
                pass_o           <= 1'b0;
                timeout_o        <= 1'b0;
                err_count_o      <= 16'd0;
                first_err_addr_o <= 32'd0;
            end else begin
                if (wd_expire) begin
                    timeout_o <= 1'b1;
                end
                if (rd_miss) begin
                    err_count_o <= sat_inc16(err_count_o);
                    if (err_count_o == 16'd0) begin
                        first_err_addr_o <= bus_addr_o;
                    end
                end
                if (state == ST_FINISH) begin
                    busy_o <= 1'b0;
                    pass_o <= (err_count_o == 16'd0) && !timeout_o;
                end
            end
        end
    end

    assign state_value = state_debug(state);

endmodule

// File: tb/tb_mem_bist.sv
// Self-checking bench for mem_bist: a table of responder scenarios run against
// a 4-word instance, plus hand sequences for reset and a 1-word instance.
module tb_mem_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_i;
    logic [31:0] seed_i;
    logic [31:0] bus_addr_o, bus_data_o, bus_data_i;
    logic        bus_we_o, bus_rd_o, bus_ack_i;
    logic        busy_o, done_o, pass_o, timeout_o;
    logic [15:0] err_count_o, state_value;
    logic [31:0] first_err_addr_o;

    mem_bist #(.BASE_ADDR(32'h0000_0100), .WORDS(4), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .seed_i(seed_i),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
        .bus_we_o(bus_we_o), .bus_rd_o(bus_rd_o), .bus_ack_i(bus_ack_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
        .state_value(state_value));

    // second instance: single word at the top of the address space
    logic        start1;
    logic [31:0] seed1, addr1, dout1, din1, first1;
    logic        we1, rd1, ack1, busy1, done1, pass1, tmo1;
    logic [15:0] err1, sv1;
    logic [31:0] mem1;

    mem_bist #(.BASE_ADDR(32'hFFFF_FFFC), .WORDS(1), .TIMEOUT(5)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .seed_i(seed1),
        .bus_addr_o(addr1), .bus_data_o(dout1), .bus_data_i(din1),
        .bus_we_o(we1), .bus_rd_o(rd1), .bus_ack_i(ack1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .timeout_o(tmo1),
        .err_count_o(err1), .first_err_addr_o(first1), .state_value(sv1));

    assign ack1 = we1 | rd1;
    assign din1 = mem1;
    always @(posedge clk) if (we1 && ack1) mem1 <= dout1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder configuration
    int          cfg_wait;
    bit          cfg_no_ack, cfg_corrupt_en, cfg_corrupt_all, cfg_spur;
    logic [31:0] cfg_corrupt_addr;

    logic [31:0] mem [0:3];
    logic [31:0] addr_off;
    logic [1:0]  idx;
    logic        req_m, real_ack;
    int          wait_cnt;

    assign req_m    = bus_we_o | bus_rd_o;
    assign addr_off = bus_addr_o - 32'h100;
    assign idx      = addr_off[3:2];
    assign real_ack = req_m && !cfg_no_ack && (wait_cnt >= cfg_wait);
    assign bus_ack_i = real_ack || (cfg_spur && busy_o && !req_m);
    assign bus_data_i = mem[idx] ^
        ((cfg_corrupt_all || (cfg_corrupt_en && bus_addr_o == cfg_corrupt_addr)) ? 32'h1 : 32'h0);

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (req_m && !bus_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk) if (bus_we_o && bus_ack_i) mem[idx] <= bus_data_o;

    // bus monitor, sampled mid-cycle
    bit          mon_clr;
    int          strobe_cyc, v_both, v_stab, v_gap, low_run;
    bit          req_seen, prev_req, prev_ack, prev_we;
    logic [31:0] prev_addr, prev_data;
    logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
    int          n_wr1, n_rd1;
    logic [31:0] wr1_addr, wr1_data;

    always @(negedge clk) begin
        if (mon_clr) begin
            strobe_cyc <= 0; v_both <= 0; v_stab <= 0; v_gap <= 0; low_run <= 0;
            req_seen <= 0; prev_req <= 0; prev_ack <= 0; prev_we <= 0;
            prev_addr <= 32'd0; prev_data <= 32'd0;
            wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
            n_wr1 <= 0; n_rd1 <= 0;
        end else begin
            if (bus_we_o && bus_rd_o) v_both <= v_both + 1;
            if (req_m && prev_req && !prev_ack &&
                (bus_addr_o != prev_addr || bus_data_o != prev_data || bus_we_o != prev_we))
                v_stab <= v_stab + 1;
            if ((req_m && prev_req && prev_ack) || (req_m && !prev_req && req_seen && low_run != 1))
                v_gap <= v_gap + 1;
            if (req_m) begin
                strobe_cyc <= strobe_cyc + 1; req_seen <= 1; low_run <= 0;
            end else begin
                low_run <= low_run + 1;
            end
            if (req_m && bus_ack_i) begin
                if (bus_we_o) begin
                    wr_addr_q.push_back(bus_addr_o); wr_data_q.push_back(bus_data_o);
                end else begin
                    rd_addr_q.push_back(bus_addr_o);
                end
            end
            prev_req <= req_m; prev_ack <= req_m && bus_ack_i; prev_we <= bus_we_o;
            prev_addr <= bus_addr_o; prev_data <= bus_data_o;
            if (we1 && ack1) begin
                n_wr1 <= n_wr1 + 1; wr1_addr <= addr1; wr1_data <= dout1;
            end
            if (rd1 && ack1) n_rd1 <= n_rd1 + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string grp, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, want %0h", grp, name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] seed;
        int          wait_n;
        bit          no_ack;
        bit          corrupt_en;
        logic [31:0] corrupt_addr;
        bit          corrupt_all;
        bit          abuse;
        bit          exp_pass;
        bit          exp_tmo;
        logic [15:0] exp_err;
        logic [31:0] exp_first;
        int          exp_done;
        int          exp_strobe;
        int          exp_nwr;
        int          exp_nrd;
        logic [31:0] exp_d0;
        logic [31:0] exp_d3;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        int  t0, dcyc;
        bit  seen, ok;
        logic [31:0] a;
        cfg_wait = v.wait_n; cfg_no_ack = v.no_ack; cfg_corrupt_en = v.corrupt_en;
        cfg_corrupt_addr = v.corrupt_addr; cfg_corrupt_all = v.corrupt_all; cfg_spur = v.abuse;
        @(posedge clk); #1 mon_clr = 1;
        @(posedge clk); #1 mon_clr = 0; start_i = 1; seed_i = v.seed; t0 = cyc;
        @(posedge clk); #1 start_i = 0;
        chk(v.name, "start_busy",  32'(busy_o), 32'd1);
        chk(v.name, "start_pass",  32'(pass_o), 32'd0);
        chk(v.name, "start_tmo",   32'(timeout_o), 32'd0);
        chk(v.name, "start_err",   32'(err_count_o), 32'd0);
        chk(v.name, "start_state", 32'(state_value), 32'd1);
        seen = 0; dcyc = -1;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (v.abuse && (cyc - t0) == 5) begin start_i = 1; seed_i = 32'hDEAD_BEEF; end
            else if (v.abuse && (cyc - t0) == 6) start_i = 0;
            if (done_o) begin seen = 1; dcyc = cyc - t0; end
        end
        chk(v.name, "done_cycle", 32'(dcyc), 32'(v.exp_done));
        chk(v.name, "end_busy",   32'(busy_o), 32'd0);
        chk(v.name, "pass",       32'(pass_o), 32'(v.exp_pass));
        chk(v.name, "timeout",    32'(timeout_o), 32'(v.exp_tmo));
        chk(v.name, "err_count",  32'(err_count_o), 32'(v.exp_err));
        chk(v.name, "first_err",  first_err_addr_o, v.exp_first);
        chk(v.name, "strobe_cyc", 32'(strobe_cyc), 32'(v.exp_strobe));
        chk(v.name, "both_strobes", 32'(v_both), 32'd0);
        chk(v.name, "stable",     32'(v_stab), 32'd0);
        chk(v.name, "gap",        32'(v_gap), 32'd0);
        chk(v.name, "n_writes",   32'(wr_addr_q.size()), 32'(v.exp_nwr));
        chk(v.name, "n_reads",    32'(rd_addr_q.size()), 32'(v.exp_nrd));
        ok = 1;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            a = 32'h100 + 32'(4 * i);
            if (wr_addr_q[i] != a || wr_data_q[i] != (a ^ v.seed)) ok = 0;
        end
        for (int i = 0; i < rd_addr_q.size(); i++) begin
            a = 32'h100 + 32'(4 * i);
            if (rd_addr_q[i] != a) ok = 0;
        end
        chk(v.name, "addr_data_seq", 32'(ok), 32'd1);
        if (v.exp_nwr == 4) begin
            chk(v.name, "wdata_0x100", wr_data_q[0], v.exp_d0);
            chk(v.name, "wdata_0x10c", wr_data_q[3], v.exp_d3);
        end
        @(negedge clk);
        chk(v.name, "done_pulse", 32'(done_o), 32'd0);
        cfg_spur = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int t0, dcyc;
        bit found, any;

        vecs[0] = '{"clean", 32'hA5A5A5A5, 0, 0, 0, 32'h0, 0, 0,
                    1, 0, 16'd0, 32'h0, 18, 8, 4, 4, 32'hA5A5A4A5, 32'hA5A5A4A9};
        vecs[1] = '{"corrupt_108", 32'hA5A5A5A5, 0, 0, 1, 32'h108, 0, 0,
                    0, 0, 16'd1, 32'h108, 18, 8, 4, 4, 32'hA5A5A4A5, 32'hA5A5A4A9};
        vecs[2] = '{"wait3", 32'h12345678, 3, 0, 0, 32'h0, 0, 0,
                    1, 0, 16'd0, 32'h0, 42, 32, 4, 4, 32'h12345778, 32'h12345774};
        vecs[3] = '{"no_ack", 32'hA5A5A5A5, 0, 1, 0, 32'h0, 0, 0,
                    0, 1, 16'd0, 32'h0, 12, 10, 0, 0, 32'h0, 32'h0};
        vecs[4] = '{"clean_after_tmo", 32'h0, 0, 0, 0, 32'h0, 0, 0,
                    1, 0, 16'd0, 32'h0, 18, 8, 4, 4, 32'h00000100, 32'h0000010C};
        vecs[5] = '{"corrupt_all_w1", 32'hFFFF0000, 1, 0, 0, 32'h0, 1, 0,
                    0, 0, 16'd4, 32'h100, 26, 16, 4, 4, 32'hFFFF0100, 32'hFFFF010C};
        vecs[6] = '{"abuse", 32'h0F0F0F0F, 0, 0, 0, 32'h0, 0, 1,
                    1, 0, 16'd0, 32'h0, 18, 8, 4, 4, 32'h0F0F0E0F, 32'h0F0F0E03};

        cfg_wait = 0; cfg_no_ack = 0; cfg_corrupt_en = 0; cfg_corrupt_all = 0;
        cfg_spur = 0; cfg_corrupt_addr = 32'h0;
        start_i = 0; seed_i = 32'h0; start1 = 0; seed1 = 32'h0; mon_clr = 1;
        rst = 0;
        #1 rst = 1;
        #2;
        chk("reset", "strobes_status",
            32'({bus_we_o, bus_rd_o, busy_o, done_o, pass_o, timeout_o}), 32'd0);
        chk("reset", "addr", bus_addr_o, 32'd0);
        chk("reset", "data", bus_data_o, 32'd0);
        chk("reset", "err_first", 32'(err_count_o) | first_err_addr_o, 32'd0);
        chk("reset", "state_value", 32'(state_value), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 0;
        any = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus_we_o || bus_rd_o || busy_o) any = 1;
        end
        chk("reset", "no_req_before_start", 32'(any), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // reset in the middle of reading word 2, then a clean run
        cfg_wait = 0; cfg_no_ack = 0; cfg_corrupt_en = 0; cfg_corrupt_all = 0;
        @(posedge clk); #1 start_i = 1; seed_i = 32'h5A5A5A5A;
        @(posedge clk); #1 start_i = 0;
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (bus_rd_o && bus_addr_o == 32'h108) found = 1;
        end
        chk("rst_mid", "reached_read_108", 32'(found), 32'd1);
        chk("rst_mid", "state_rd_req", 32'(state_value), 32'd3);
        #2 rst = 1;
        #1;
        chk("rst_mid", "strobes_status",
            32'({bus_we_o, bus_rd_o, busy_o, done_o, pass_o, timeout_o}), 32'd0);
        chk("rst_mid", "addr_data", bus_addr_o | bus_data_o, 32'd0);
        chk("rst_mid", "state_value", 32'(state_value), 32'd0);
        @(posedge clk); #1 rst = 0;
        run_vec(vecs[0]);

        // single-word instance at the last legal address
        @(posedge clk); #1 mon_clr = 1;
        @(posedge clk); #1 mon_clr = 0; start1 = 1; seed1 = 32'h12345678; t0 = cyc;
        @(posedge clk); #1 start1 = 0;
        dcyc = -1;
        for (int k = 0; k < 100 && dcyc < 0; k++) begin
            @(negedge clk);
            if (done1) dcyc = cyc - t0;
        end
        chk("words1", "done_cycle", 32'(dcyc), 32'd6);
        chk("words1", "n_writes", 32'(n_wr1), 32'd1);
        chk("words1", "n_reads", 32'(n_rd1), 32'd1);
        chk("words1", "wr_addr", wr1_addr, 32'hFFFF_FFFC);
        chk("words1", "wr_data", wr1_data, 32'hEDCB_A984);
        chk("words1", "pass", 32'(pass1), 32'd1);
        chk("words1", "err_tmo", 32'({tmo1, err1}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
